dot_arbiter: RTL and testbench
==============================

Name: dot_arbiter

Overview:
- Shares one fp32_dot pipeline between NUM_REQ requesters, e.g. the view/projection matrix generator and the per-vertex transform unit.
- Grants issue slots round-robin and tags each issued operation with its requester index.
- Routes each dot-product result back to the requester that issued it.
- Latency-agnostic: returning results are matched to tags in issue order through an in-flight tag FIFO.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MAX_INFLIGHT, 16, tag FIFO depth; the maximum number of operations in the dot pipeline at once (power of 2).

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, synchronous, active-low; the fp32_dot instance shares this reset.
- req_valid_in  input  NUM_REQ  per-requester operation request.
- req_ready_out  output  NUM_REQ  per-requester accept, one-hot or zero.
- req_a_in  input  NUM_REQ x [3:0][31:0]  per-requester fp32 vector A.
- req_b_in  input  NUM_REQ x [3:0][31:0]  per-requester fp32 vector B.
- resp_valid_out  output  NUM_REQ  one-hot result strobe.
- resp_c_out  output  32  fp32 result, shared by all requesters; qualified by resp_valid_out.
- dot_valid_out  output  1  issue strobe to fp32_dot valid_in.
- dot_a_out  output  [3:0][31:0]  to fp32_dot a_in.
- dot_b_out  output  [3:0][31:0]  to fp32_dot b_in.
- dot_valid_in  input  1  from fp32_dot valid_out.
- dot_c_in  input  32  from fp32_dot c_out.
- busy_out  output  1  high while any operation is in flight or a result is pending output.
- err_out  output  1  sticky: a result arrived while the tag FIFO was empty.

Behaviour:
- Reset (rst_n_in low at a clock edge) sets:
  - all outputs to 0;
  - round-robin pointer to 0;
  - tag FIFO empty, count 0;
  - err_out cleared.
- Full = (registered count == MAX_INFLIGHT).
- Arbitration is combinational:
  - search starts at the pointer and proceeds upward with wrap-around;
  - the first requester with req_valid_in high is the grant;
  - req_ready_out[g] = grant one-hot AND NOT full;
  - at most one ready bit is high per cycle.
- Handshake: an operation is accepted on a cycle where valid and ready are both high. Requesters hold valid, A and B stable until accepted; valid must not be withdrawn before accept.
- Issue, one cycle after accept:
  - dot_valid_out = 1;
  - dot_a_out / dot_b_out = the accepted A/B, registered;
  - tag g pushed to the FIFO;
  - pointer set to (g+1) mod NUM_REQ.
- Issue, no accept that cycle:
  - dot_valid_out = 0;
  - dot_a_out / dot_b_out hold their values;
  - pointer unchanged.
- Sustained throughput: one operation per cycle while not full.
- Return, when dot_valid_in is high:
  - pop the FIFO head tag t;
  - next cycle: resp_valid_out = one-hot(t), resp_c_out = dot_c_in.
- Response latency = fp32_dot latency + 1 cycle.
- Requesters have no response backpressure and must accept the response on the strobe cycle.
- FIFO ordering: results return in issue order, as guaranteed by the in-order fp32_dot pipeline.
- Simultaneous push and pop: count is unchanged.
- Full with a pop in the same cycle: ready stays low that cycle, because full uses the registered count. The slot frees on the next cycle.
- Empty with dot_valid_in high:
  - err_out set (sticky until reset);
  - no resp_valid_out generated;
  - FIFO pointers unchanged.
- Reset mid-operation: the FIFO and the dot pipeline both flush, so nothing is returned for operations in flight at reset.
- busy_out = (count != 0) OR any resp_valid_out bit high.
- Counter widths:
  - count is $clog2(MAX_INFLIGHT)+1 bits;
  - FIFO read/write pointers are $clog2(MAX_INFLIGHT) bits and wrap naturally.
- No arithmetic on fp32 data; the block routes values only.

Decomposition:
- Shared package graphics_pkg:
  - FP32_ONE (32'h3F800000) and FP32_ZERO constants;
  - vec4 typedef ([3:0][31:0]);
  - req_tag_t typedef sized $clog2(NUM_REQ).
- One sub-module, tag_fifo: synchronous FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - Same clock and reset as the parent.
- Round-robin arbiter stays inline.

Test Plan:
- Reset: hold rst_n_in low 2 cycles with requests pending -> all ready/resp/dot_valid outputs 0, busy_out 0, err_out 0; first grant after release goes to requester 0.
- Single op: req 1 sends A={1.0,2.0,3.0,0} (3F800000,40000000,40400000,0), B={1.0,1.0,1.0,0} -> dot_valid_out 1 cycle after accept; resp_valid_out=2'b10 with resp_c_out=40C00000 (6.0) at dot latency+1.
- Fairness: both requesters hold valid for 8 accepts -> grants alternate 0,1,0,1,…; each gets 4; responses arrive tagged in the same alternating order.
- Full: stub dot returns nothing until MAX_INFLIGHT=16 ops issued -> ready is 0 on the 17th cycle. Then one dot_valid_in plus a pending request -> no accept that cycle, accept on the next.
- Spurious result: dot_valid_in pulsed with FIFO empty -> err_out rises and stays high, no resp_valid_out; rst_n_in low clears err_out.
- Reset mid-flight: 5 ops in flight, assert reset -> no responses afterward, busy_out 0; new requests then work normally.

Source files
------------

// File: rtl/graphics_pkg.sv
// graphics_pkg: shared fp32 constants and vector/tag types for the graphics datapath
package graphics_pkg;
  localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam int MAX_REQ = 8;
  typedef logic [3:0][31:0] vec4;
  typedef logic [$clog2(MAX_REQ)-1:0] req_tag_t;
endpackage

// File: rtl/tag_fifo.sv
// tag_fifo: synchronous FIFO holding requester tags of operations in flight
module tag_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];
  // pointers wrap naturally; overflow/underflow requests are ignored
  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // pointer and occupancy state
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // tag storage needs no reset: only entries below count are ever read
  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/dot_arbiter.sv
// dot_arbiter: round-robin sharing of one fp32_dot pipeline with tag-routed results
module dot_arbiter
  import graphics_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  output logic [NUM_REQ-1:0]             req_ready_out,
  input  logic [NUM_REQ-1:0][3:0][31:0]  req_a_in,
  input  logic [NUM_REQ-1:0][3:0][31:0]  req_b_in,
  output logic [NUM_REQ-1:0]             resp_valid_out,
  output logic [31:0]                    resp_c_out,
  output logic                           dot_valid_out,
  output vec4                            dot_a_out,
  output vec4                            dot_b_out,
  input  logic                           dot_valid_in,
  input  logic [31:0]                    dot_c_in,
  output logic                           busy_out,
  output logic                           err_out
);
  localparam int CW = $clog2(MAX_INFLIGHT) + 1;
  req_tag_t ptr_q, ptr_d, grant_idx, cand, fifo_dout;
  logic [MAX_REQ-1:0] valid_ext, grant_ext;
  logic found, accept, pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  vec4 a_sel, b_sel, dot_a_q, dot_a_d, dot_b_q, dot_b_d;
  logic dot_valid_q, dot_valid_d, err_q, err_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [31:0] resp_c_q, resp_c_d;
  assign valid_ext = MAX_REQ'(req_valid_in);
  // full is judged on the registered count, so a same-cycle pop does not reopen the slot
  assign req_ready_out = grant_ext[NUM_REQ-1:0] & {NUM_REQ{rst_n_in & ~fifo_full}};
  assign accept = |req_ready_out;
  assign pop = dot_valid_in & ~fifo_empty;
  // round-robin search from the pointer upward with wrap-around
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    grant_ext = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = req_tag_t'((32'(ptr_q) + 32'(i)) % 32'(NUM_REQ));
      if (!found && valid_ext[cand]) begin
        found          = 1'b1;
        grant_idx      = cand;
        grant_ext[cand] = 1'b1;
      end
    end
  end
  // operand mux for the granted requester and next-state for issue/return registers
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_ext[i]) begin
        a_sel = req_a_in[i];
        b_sel = req_b_in[i];
      end
    end
    dot_valid_d = accept;
    dot_a_d     = accept ? a_sel : dot_a_q;
    dot_b_d     = accept ? b_sel : dot_b_q;
    ptr_d       = !accept ? ptr_q : (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    for (int i = 0; i < NUM_REQ; i++) resp_valid_d[i] = pop & (fifo_dout == req_tag_t'(i));
    resp_c_d    = pop ? dot_c_in : resp_c_q;
    err_d       = err_q | (dot_valid_in & fifo_empty);
  end
  // registered issue, response and error state
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      ptr_q        <= '0;
      dot_valid_q  <= 1'b0;
      dot_a_q      <= '0;
      dot_b_q      <= '0;
      resp_valid_q <= '0;
      resp_c_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      dot_valid_q  <= dot_valid_d;
      dot_a_q      <= dot_a_d;
      dot_b_q      <= dot_b_d;
      resp_valid_q <= resp_valid_d;
      resp_c_q     <= resp_c_d;
      err_q        <= err_d;
    end
  end
  tag_fifo #(.WIDTH($bits(req_tag_t)), .DEPTH(MAX_INFLIGHT)) u_tag_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .push     (accept),
    .pop      (pop),
    .din      (grant_idx),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );
  assign dot_valid_out  = dot_valid_q;
  assign dot_a_out      = dot_a_q;
  assign dot_b_out      = dot_b_q;
  assign resp_valid_out = resp_valid_q;
  assign resp_c_out     = resp_c_q;
  assign err_out        = err_q;
  assign busy_out       = (fifo_count != '0) | (|resp_valid_q);
endmodule

// File: tb/tb_dot_arbiter.sv
// tb_dot_arbiter: directed self-checking bench for dot_arbiter with a hand-driven dot stub
module tb_dot_arbiter;
  import graphics_pkg::*;
  logic clk_in = 1'b0;
  logic rst_n_in;
  logic [1:0] req_valid_in, req_ready_out, resp_valid_out;
  logic [1:0][3:0][31:0] req_a_in, req_b_in;
  logic [31:0] resp_c_out, dot_c_in;
  logic dot_valid_out, dot_valid_in, busy_out, err_out;
  vec4 dot_a_out, dot_b_out;
  int checks = 0, errors = 0, n0 = 0, n1 = 0;
  logic [1:0] exp2;

  dot_arbiter #(.NUM_REQ(2), .MAX_INFLIGHT(16)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_a_in(req_a_in), .req_b_in(req_b_in),
    .resp_valid_out(resp_valid_out), .resp_c_out(resp_c_out),
    .dot_valid_out(dot_valid_out), .dot_a_out(dot_a_out), .dot_b_out(dot_b_out),
    .dot_valid_in(dot_valid_in), .dot_c_in(dot_c_in),
    .busy_out(busy_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n_in = 1'b0;
    req_valid_in = 2'b11;
    dot_valid_in = 1'b0;
    dot_c_in = '0;
    req_a_in[0] = {32'h0, 32'h4080_0000, 32'h4040_0000, 32'h4000_0000};
    req_b_in[0] = {32'h0, FP32_ZERO, FP32_ONE, FP32_ONE};
    req_a_in[1] = {32'h0, 32'h4040_0000, 32'h4000_0000, FP32_ONE};
    req_b_in[1] = {32'h0, FP32_ONE, FP32_ONE, FP32_ONE};
    // reset with requests pending
    tick();
    tick();
    chk("rst_ready", req_ready_out, 2'b00);
    chk("rst_resp", resp_valid_out, 2'b00);
    chk("rst_dot_valid", dot_valid_out, 1'b0);
    chk("rst_busy", busy_out, 1'b0);
    chk("rst_err", err_out, 1'b0);
    rst_n_in = 1'b1;
    #1;
    chk("first_grant", req_ready_out, 2'b01);
    tick();
    req_valid_in = 2'b00;
    #1;
    chk("r0_issue", dot_valid_out, 1'b1);
    chk("r0_a", dot_a_out, req_a_in[0]);
    chk("r0_busy", busy_out, 1'b1);
    dot_valid_in = 1'b1;
    dot_c_in = 32'h4080_0000;
    tick();
    dot_valid_in = 1'b0;
    chk("r0_resp", resp_valid_out, 2'b01);
    chk("r0_c", resp_c_out, 32'h4080_0000);
    tick();
    chk("r0_resp_clr", resp_valid_out, 2'b00);
    chk("r0_idle", busy_out, 1'b0);
    // single op from requester 1: {1,2,3,0}.{1,1,1,0} = 6.0
    req_valid_in = 2'b10;
    #1;
    chk("r1_ready", req_ready_out, 2'b10);
    tick();
    req_valid_in = 2'b00;
    #1;
    chk("r1_issue", dot_valid_out, 1'b1);
    chk("r1_a", dot_a_out, req_a_in[1]);
    chk("r1_b", dot_b_out, req_b_in[1]);
    tick();
    chk("r1_issue_clr", dot_valid_out, 1'b0);
    chk("r1_a_hold", dot_a_out, req_a_in[1]);
    dot_valid_in = 1'b1;
    dot_c_in = 32'h40C0_0000;
    tick();
    dot_valid_in = 1'b0;
    chk("r1_resp", resp_valid_out, 2'b10);
    chk("r1_c", resp_c_out, 32'h40C0_0000);
    // fairness: both requesting, grants alternate starting at 0
    req_valid_in = 2'b11;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp2 = (i % 2 == 1) ? 2'b10 : 2'b01;
      chk("fair_ready", req_ready_out, exp2);
      if (req_ready_out == 2'b01) n0++;
      if (req_ready_out == 2'b10) n1++;
      tick();
    end
    req_valid_in = 2'b00;
    chk("fair_n0", n0, 4);
    chk("fair_n1", n1, 4);
    dot_valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dot_c_in = 32'h100 + 32'(i);
      tick();
      exp2 = (i % 2 == 1) ? 2'b10 : 2'b01;
      chk("fair_resp", resp_valid_out, exp2);
      chk("fair_c", resp_c_out, 32'h100 + 32'(i));
    end
    dot_valid_in = 1'b0;
    tick();
    chk("fair_idle", busy_out, 1'b0);
    // fill the tag FIFO with 16 ops from requester 0
    req_valid_in = 2'b01;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("fill_ready", req_ready_out, 2'b01);
      tick();
    end
    #1;
    chk("full_ready", req_ready_out, 2'b00);
    dot_valid_in = 1'b1;
    dot_c_in = 32'hAAAA_0000;
    #1;
    chk("full_pop_ready", req_ready_out, 2'b00);
    tick();
    dot_valid_in = 1'b0;
    #1;
    chk("full_pop_resp", resp_valid_out, 2'b01);
    chk("full_reopen", req_ready_out, 2'b01);
    tick();
    req_valid_in = 2'b00;
    chk("full_refill_issue", dot_valid_out, 1'b1);
    dot_valid_in = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    dot_valid_in = 1'b0;
    chk("drain_last_resp", resp_valid_out, 2'b01);
    tick();
    chk("drain_idle", busy_out, 1'b0);
    chk("drain_err", err_out, 1'b0);
    // spurious result with an empty FIFO
    dot_valid_in = 1'b1;
    tick();
    dot_valid_in = 1'b0;
    chk("spur_err", err_out, 1'b1);
    chk("spur_resp", resp_valid_out, 2'b00);
    tick();
    chk("spur_sticky", err_out, 1'b1);
    chk("spur_busy", busy_out, 1'b0);
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    chk("spur_clear", err_out, 1'b0);
    // reset with 5 ops in flight
    req_valid_in = 2'b11;
    for (int i = 0; i < 5; i++) tick();
    req_valid_in = 2'b00;
    chk("mid_busy", busy_out, 1'b1);
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    chk("mid_flushed", busy_out, 1'b0);
    tick();
    tick();
    chk("mid_no_resp", resp_valid_out, 2'b00);
    req_valid_in = 2'b10;
    #1;
    chk("post_ready", req_ready_out, 2'b10);
    tick();
    req_valid_in = 2'b00;
    chk("post_issue", dot_valid_out, 1'b1);
    chk("post_a", dot_a_out, req_a_in[1]);
    dot_valid_in = 1'b1;
    dot_c_in = 32'h40C0_0000;
    tick();
    dot_valid_in = 1'b0;
    chk("post_resp", resp_valid_out, 2'b10);
    chk("post_c", resp_c_out, 32'h40C0_0000);
    chk("post_err", err_out, 1'b0);
    tick();
    chk("post_idle", busy_out, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
